writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter WORD, default 64, which is the register data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, which is the number of queue entries and SHALL be a power of two, at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port enq_valid, input, 1 bit: a pending register write is offered.
REQ-006 The block SHALL have port enq_ready, output, 1 bit: the queue can accept an offer this cycle.
REQ-007 The block SHALL have port enq_register, input, 5 bits: destination register of the offer.
REQ-008 The block SHALL have port enq_data, input, WORD bits: data of the offer.
REQ-009 The block SHALL have port stall, input, 1 bit: the write port is busy, so hold the drain.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all queued entries.
REQ-011 The block SHALL have port write_register, output, 5 bits: regfile write address, registered.
REQ-012 The block SHALL have port write_data, output, WORD bits: regfile write data, registered.
REQ-013 The block SHALL have port reg_write, output, 1 bit: regfile write enable, registered, one-cycle pulse per drained entry.
REQ-014 The block SHALL have port lookup_register, input, 5 bits: register probed by the decode stage.
REQ-015 The block SHALL have port lookup_hit, output, 1 bit: a pending write to lookup_register exists.
REQ-016 The block SHALL have port lookup_data, output, WORD bits: youngest pending data for lookup_register, 0 when there is no hit.
REQ-017 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-018 The block SHALL have port empty, output, 1 bit: count == 0.

Function
REQ-019 enq_ready SHALL equal !full, combinationally from count; a same-cycle drain SHALL NOT make a full queue ready.
REQ-020 An offer SHALL be accepted at a rising edge where enq_valid && enq_ready && !flush; the entry is stored at the tail, which advances modulo DEPTH.
REQ-021 An accepted offer with enq_register == 31 (XZR) SHALL be consumed but not stored; count and pointers are unchanged.
REQ-022 The drain SHALL pop the head at each rising edge where !empty && !stall && !flush, and load write_register/write_data from the head with reg_write=1 for that next cycle.
REQ-023 On any edge with no pop, reg_write SHALL be 0 and write_register/write_data SHALL hold their previous values.
REQ-024 Latency: an entry accepted into an empty queue at edge N SHALL appear with reg_write=1 after edge N+1, absent stall and flush.
REQ-025 Simultaneous accept and pop SHALL leave count unchanged and advance both pointers.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or reordering; drain order equals accept order.
REQ-027 flush SHALL, at the rising edge, set count=0, equalise the pointers, and force reg_write=0; flush SHALL take priority over accept and pop.
REQ-028 lookup SHALL be combinational over the valid queue entries plus the output stage when reg_write=1. The youngest queue entry SHALL win over older entries, and any queue entry SHALL win over the output stage.
REQ-029 lookup_register == 31 SHALL give lookup_hit=0 and lookup_data=0.

Reset
REQ-030 While rst_n=0, the block SHALL force count=0, pointers=0, empty=1, enq_ready=1, reg_write=0, write_register=0, write_data=0, lookup_hit=0.
REQ-031 Reset asserted mid-operation SHALL discard all entries; no reg_write pulse SHALL occur until a new accept after rst_n rises.

Structure
REQ-032 Shared package arm_pkg SHALL hold WORD, REG_ADDR_W=5, and XZR=5'd31.
REQ-033 Entry storage and the youngest-match search SHALL be one sub-module, wbq_storage; pointers, count, and the output stage SHALL reside in writeback_queue.

Verification
REQ-034 Scenario 1 SHALL check: after reset, accept r3=55 -> one cycle later reg_write=1, write_register=3, write_data=55, then reg_write=0 and empty=1.
REQ-035 Scenario 2 SHALL check: stall=1, accept r1=10, r2=20, r3=30, r4=40 -> count=4, enq_ready=0, an r5 offer is refused; release stall -> four pulses in order r1..r4 on consecutive cycles.
REQ-036 Scenario 3 SHALL check: with stall=1, queue r15=-354 then r15=23456; lookup 15 -> hit=1, data=23456; lookup 12 -> hit=0, data=0.
REQ-037 Scenario 4 SHALL check: accept r31=99 -> count stays 0, no reg_write pulse; lookup 31 -> hit=0.
REQ-038 Scenario 5 SHALL check: 10 entries streamed with stall toggled every other cycle -> pointers wrap and all 10 drain in order with no duplicates.
REQ-039 Scenario 6 SHALL check: with 3 entries queued, assert flush concurrently with enq_valid -> count=0, reg_write=0 next cycle, offer dropped; repeat with rst_n pulsed low mid-drain -> all outputs at reset values immediately.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared architectural constants for the integer register file path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package arm_pkg;
    localparam int WORD       = 64;
    localparam int REG_ADDR_W = 5;
    // Register 31 reads as zero, so writes to it are architecturally dead.
    localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;
endpackage

// File: rtl/writeback_queue_if.sv
// Enqueue, drain, lookup and status bundle of the writeback queue.
// Latency: n/a (wiring only).
// Backpressure: enq_ready from the queue gates enq_valid; stall holds the drain.
interface writeback_queue_if #(
    parameter int WORD  = arm_pkg::WORD,
    parameter int DEPTH = 4
);
    localparam int RW = arm_pkg::REG_ADDR_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic            enq_valid;
    logic            enq_ready;
    logic [RW-1:0]   enq_register;
    logic [WORD-1:0] enq_data;
    logic            stall;
    logic            flush;
    logic [RW-1:0]   write_register;
    logic [WORD-1:0] write_data;
    logic            reg_write;
    logic [RW-1:0]   lookup_register;
    logic            lookup_hit;
    logic [WORD-1:0] lookup_data;
    logic [CW-1:0]   count;
    logic            empty;

    modport master (
        output enq_valid, enq_register, enq_data, stall, flush, lookup_register,
        input  enq_ready, write_register, write_data, reg_write,
        input  lookup_hit, lookup_data, count, empty
    );

    modport slave (
        input  enq_valid, enq_register, enq_data, stall, flush, lookup_register,
        output enq_ready, write_register, write_data, reg_write,
        output lookup_hit, lookup_data, count, empty
    );
endinterface

// File: rtl/wbq_storage.sv
// Entry array of the writeback queue plus the youngest-match register search.
// Latency: write lands at the clock edge; head read and search are combinational.
// Backpressure: none here; the parent only writes when a slot is free.
module wbq_storage
    import arm_pkg::REG_ADDR_W;
#(
    parameter int WORD  = 64,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [PW-1:0]         i_wr_ptr,
    input  logic [REG_ADDR_W-1:0] i_wr_reg,
    input  logic [WORD-1:0]       i_wr_data,
    input  logic [PW-1:0]         i_rd_ptr,
    input  logic [CW-1:0]         i_count,
    input  logic [REG_ADDR_W-1:0] i_lookup_reg,
    output logic [REG_ADDR_W-1:0] o_head_reg,
    output logic [WORD-1:0]       o_head_data,
    output logic                  o_hit,
    output logic [WORD-1:0]       o_hit_data
);
    logic [REG_ADDR_W-1:0] r_reg  [DEPTH];
    logic [WORD-1:0]       r_data [DEPTH];
    logic [PW-1:0]         w_slot;

    // Store an accepted entry at the tail slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_reg[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_reg[i_wr_ptr]  <= i_wr_reg;
            r_data[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_head_reg  = r_reg[i_rd_ptr];
    assign o_head_data = r_data[i_rd_ptr];

    // Walk live entries oldest to youngest so the last match (youngest) wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_slot = i_rd_ptr + PW'(i);
            if ((CW'(i) < i_count) && (r_reg[w_slot] == i_lookup_reg)) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[w_slot];
            end
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// Pending register-write queue draining into a registered regfile write port, with forwarding lookup.
// Latency: entry accepted into an empty queue at edge N is driven with reg_write=1 after edge N+1.
// Backpressure: enq_ready drops when full (a same-cycle drain does not free a slot); stall holds the drain.
module writeback_queue
    import arm_pkg::REG_ADDR_W;
    import arm_pkg::XZR;
#(
    parameter int WORD  = arm_pkg::WORD,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_write_register;
    logic [WORD-1:0]       r_write_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_accept;
    logic                  w_store;
    logic                  w_pop;
    logic [REG_ADDR_W-1:0] w_head_reg;
    logic [WORD-1:0]       w_head_data;
    logic                  w_q_hit;
    logic [WORD-1:0]       w_q_data;
    logic                  w_hit;
    logic [WORD-1:0]       w_hit_data;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = bus.enq_valid && !w_full && !bus.flush;
    // XZR writes are consumed but never occupy a slot.
    assign w_store  = w_accept && (bus.enq_register != XZR);
    assign w_pop    = !w_empty && !bus.stall && !bus.flush;

    wbq_storage #(
        .WORD  (WORD),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (w_store),
        .i_wr_ptr     (r_wr_ptr),
        .i_wr_reg     (bus.enq_register),
        .i_wr_data    (bus.enq_data),
        .i_rd_ptr     (r_rd_ptr),
        .i_count      (r_count),
        .i_lookup_reg (bus.lookup_register),
        .o_head_reg   (w_head_reg),
        .o_head_data  (w_head_data),
        .o_hit        (w_q_hit),
        .o_hit_data   (w_q_data)
    );

    // Pointer and occupancy tracking; flush empties the queue ahead of any accept or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: one-cycle write pulse per popped entry, address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
        end else if (w_pop) begin
            r_reg_write      <= 1'b1;
            r_write_register <= w_head_reg;
            r_write_data     <= w_head_data;
        end else begin
            r_reg_write      <= 1'b0;
        end
    end

    // Forwarding: queued entries beat the in-flight output stage; XZR never hits.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        if (bus.lookup_register != XZR) begin
            if (w_q_hit) begin
                w_hit      = 1'b1;
                w_hit_data = w_q_data;
            end else if (r_reg_write && (r_write_register == bus.lookup_register)) begin
                w_hit      = 1'b1;
                w_hit_data = r_write_data;
            end
        end
    end

    assign bus.enq_ready      = !w_full;
    assign bus.count          = r_count;
    assign bus.empty          = w_empty;
    assign bus.reg_write      = r_reg_write;
    assign bus.write_register = r_write_register;
    assign bus.write_data     = r_write_data;
    assign bus.lookup_hit     = w_hit;
    assign bus.lookup_data    = w_hit_data;
endmodule

// File: tb/tb_writeback_queue.sv
// Scenario bench for writeback_queue with an in-order drain scoreboard.
// Latency: drives inputs 1ns after the rising edge, samples before the next edge.
// Backpressure: offers are retried by the stream scenario until enq_ready.
module tb_writeback_queue;
    localparam int WORD  = 64;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]      r;
        logic [WORD-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    ent_t sb[$];
    ent_t m_exp;

    writeback_queue_if #(.WORD(WORD), .DEPTH(DEPTH)) bus ();

    writeback_queue #(.WORD(WORD), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drain monitor: every pulse must match the oldest expected entry; then record the next accept.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.reg_write === 1'b1) begin
                n_pulses++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL drain_unexpected: got r%0d=%0d, required no pulse", bus.write_register, bus.write_data);
                end else begin
                    m_exp = sb.pop_front();
                    if ({bus.write_register, bus.write_data} !== m_exp) begin
                        n_fail++;
                        $display("FAIL drain_order: got r%0d=%0d, required r%0d=%0d", bus.write_register, bus.write_data, m_exp.r, m_exp.d);
                    end
                end
            end
            if (bus.enq_valid && bus.enq_ready && !bus.flush && bus.enq_register != 5'd31)
                sb.push_back('{bus.enq_register, bus.enq_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.enq_valid = 1'b0; bus.enq_register = '0; bus.enq_data = '0;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.lookup_register = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic offer(input logic [4:0] r, input logic [WORD-1:0] d);
        bus.enq_valid = 1'b1; bus.enq_register = r; bus.enq_data = d;
        tick();
        bus.enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.lookup_register = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, required 1", bus.empty); end
        n_checks++; if (bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", bus.enq_ready); end
        n_checks++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write: got %b, required 0", bus.reg_write); end
        n_checks++; if (bus.write_register !== 5'd0 || bus.write_data !== 64'd0) begin n_fail++; $display("FAIL reset_write_port: got r%0d=%0d, required r0=0", bus.write_register, bus.write_data); end
        n_checks++; if (bus.lookup_hit !== 1'b0) begin n_fail++; $display("FAIL reset_lookup_hit: got %b, required 0", bus.lookup_hit); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.enq_valid = 1'b1; bus.enq_register = 5'd3; bus.enq_data = 64'd55;
        tick();
        bus.enq_valid = 1'b0;
        n_checks++; if (bus.count !== 3'd1 || bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL single_accept: got count=%0d reg_write=%b, required 1/0", bus.count, bus.reg_write); end
        tick();
        n_checks++; if (bus.reg_write !== 1'b1 || bus.write_register !== 5'd3 || bus.write_data !== 64'd55) begin n_fail++; $display("FAIL single_latency: got we=%b r%0d=%0d, required we=1 r3=55", bus.reg_write, bus.write_register, bus.write_data); end
        tick();
        n_checks++; if (bus.reg_write !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL single_after: got we=%b empty=%b, required 0/1", bus.reg_write, bus.empty); end
    endtask

    task automatic test_fill_stall();
        bus.stall = 1'b1;
        for (int i = 1; i <= 4; i++) offer(5'(i), 64'(i * 10));
        n_checks++; if (bus.count !== 3'd4 || bus.enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got count=%0d ready=%b, required 4/0", bus.count, bus.enq_ready); end
        offer(5'd5, 64'd50);
        n_checks++; if (bus.count !== 3'd4) begin n_fail++; $display("FAIL full_refuse: got count=%0d, required 4", bus.count); end
        bus.stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++; if (bus.reg_write !== 1'b1 || bus.write_register !== 5'(i) || bus.write_data !== 64'(i * 10)) begin n_fail++; $display("FAIL full_drain_%0d: got we=%b r%0d=%0d, required we=1 r%0d=%0d", i, bus.reg_write, bus.write_register, bus.write_data, i, i * 10); end
        end
        tick();
        n_checks++; if (bus.reg_write !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL full_done: got we=%b empty=%b, required 0/1", bus.reg_write, bus.empty); end
    endtask

    task automatic test_lookup();
        bus.stall = 1'b1;
        offer(5'd15, -64'sd354);
        offer(5'd15, 64'd23456);
        offer(5'd7, 64'd70);
        bus.lookup_register = 5'd15; #1;
        n_checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 64'd23456) begin n_fail++; $display("FAIL lookup_youngest: got hit=%b data=%0d, required 1/23456", bus.lookup_hit, bus.lookup_data); end
        bus.lookup_register = 5'd12; #1;
        n_checks++; if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 64'd0) begin n_fail++; $display("FAIL lookup_miss: got hit=%b data=%0d, required 0/0", bus.lookup_hit, bus.lookup_data); end
        bus.stall = 1'b0;
        bus.lookup_register = 5'd15;
        tick();
        n_checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 64'd23456) begin n_fail++; $display("FAIL lookup_queue_over_output: got hit=%b data=%0d, required 1/23456", bus.lookup_hit, bus.lookup_data); end
        tick();
        tick();
        bus.lookup_register = 5'd7; #1;
        n_checks++; if (bus.lookup_hit !== 1'b1 || bus.lookup_data !== 64'd70) begin n_fail++; $display("FAIL lookup_output_stage: got hit=%b data=%0d, required 1/70", bus.lookup_hit, bus.lookup_data); end
        bus.lookup_register = 5'd15; #1;
        n_checks++; if (bus.lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_drained: got hit=%b, required 0", bus.lookup_hit); end
        bus.lookup_register = 5'd7;
        tick();
        n_checks++; if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 64'd0) begin n_fail++; $display("FAIL lookup_after_pulse: got hit=%b data=%0d, required 0/0", bus.lookup_hit, bus.lookup_data); end
    endtask

    task automatic test_xzr();
        offer(5'd31, 64'd99);
        n_checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL xzr_count: got count=%0d empty=%b, required 0/1", bus.count, bus.empty); end
        tick();
        n_checks++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL xzr_pulse: got reg_write=%b, required 0", bus.reg_write); end
        bus.lookup_register = 5'd31; #1;
        n_checks++; if (bus.lookup_hit !== 1'b0 || bus.lookup_data !== 64'd0) begin n_fail++; $display("FAIL xzr_lookup: got hit=%b data=%0d, required 0/0", bus.lookup_hit, bus.lookup_data); end
    endtask

    task automatic test_wrap();
        int       sent;
        int       cyc;
        logic     will;
        sent = 0; cyc = 0; n_pulses = 0;
        bus.enq_data = {$urandom(), $urandom()};
        while (sent < 10 && cyc < 200) begin
            bus.stall = cyc[0];
            bus.enq_valid = 1'b1;
            bus.enq_register = 5'(sent + 1);
            will = bus.enq_ready;
            tick();
            cyc++;
            if (will) begin
                sent++;
                bus.enq_data = {$urandom(), $urandom()};
            end
        end
        bus.enq_valid = 1'b0;
        bus.stall = 1'b0;
        cyc = 0;
        while ((bus.empty !== 1'b1 || bus.reg_write === 1'b1) && cyc < 50) begin
            tick();
            cyc++;
        end
        n_checks++; if (sent != 10) begin n_fail++; $display("FAIL wrap_accept: got %0d accepted, required 10", sent); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_drain_timeout: got empty=%b, required 1", bus.empty); end
        n_checks++; if (n_pulses != 10) begin n_fail++; $display("FAIL wrap_pulses: got %0d, required 10", n_pulses); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_leftover: got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_flush_reset();
        bus.stall = 1'b1;
        offer(5'd1, 64'd111);
        offer(5'd2, 64'd222);
        offer(5'd3, 64'd333);
        n_checks++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d, required 3", bus.count); end
        bus.stall = 1'b0; bus.flush = 1'b1;
        bus.enq_valid = 1'b1; bus.enq_register = 5'd9; bus.enq_data = 64'd999;
        tick();
        bus.flush = 1'b0; bus.enq_valid = 1'b0;
        sb.delete();
        n_checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_state: got count=%0d empty=%b we=%b, required 0/1/0", bus.count, bus.empty, bus.reg_write); end
        tick();
        n_checks++; if (bus.count !== 3'd0 || bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got count=%0d we=%b, required 0/0", bus.count, bus.reg_write); end

        bus.stall = 1'b1;
        offer(5'd4, 64'd444);
        offer(5'd5, 64'd555);
        offer(5'd6, 64'd666);
        bus.stall = 1'b0;
        bus.lookup_register = 5'd5;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        n_checks++; if (bus.reg_write !== 1'b0 || bus.write_register !== 5'd0 || bus.write_data !== 64'd0) begin n_fail++; $display("FAIL rst_mid_write_port: got we=%b r%0d=%0d, required 0 r0=0", bus.reg_write, bus.write_register, bus.write_data); end
        n_checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.enq_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_status: got count=%0d empty=%b ready=%b, required 0/1/1", bus.count, bus.empty, bus.enq_ready); end
        n_checks++; if (bus.lookup_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_lookup: got hit=%b, required 0", bus.lookup_hit); end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.reg_write !== 1'b0 || bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after: got we=%b empty=%b, required 0/1", bus.reg_write, bus.empty); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        apply_reset();
        test_fill_stall();
        apply_reset();
        test_lookup();
        apply_reset();
        test_xzr();
        apply_reset();
        test_wrap();
        apply_reset();
        test_flush_reset();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL final_scoreboard: got %0d pending, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
